// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through every channel and assembles the sampled outputs into one word.
// Define MUX_SCAN_CONTINUOUS_EN to restart scanning straight after each output handshake.
module mux_scan_ctrl #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              y_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d, word_q, word_d;
    logic              valid_q, valid_d, busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_SETTLE;
                sel_d    = '0;
                cnt_d    = '0;
                shadow_d = '0;
            end
            S_SETTLE: begin
                cnt_d   = (cnt_q == 4'(SETTLE - 1)) ? '0 : cnt_q + 4'd1;
                state_d = (cnt_q == 4'(SETTLE - 1)) ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: begin
                shadow_d[sel_q] = y_in;
                if (sel_q == SEL_W'(NUM_CH - 1)) begin
                    word_d  = shadow_d;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = S_SETTLE;
                end
            end
            S_HOLD: if (word_ready) begin
                valid_d = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                state_d  = S_SETTLE;
                sel_d    = '0;
                cnt_d    = '0;
                shadow_d = '0;
`else
                state_d  = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign word_out   = word_q;
    assign word_valid = valid_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a mux model, checked against a scan-schedule reference.
module tb_mux_scan_ctrl;
    localparam int N = 4;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      start, ready, y, busy, valid;
    logic [1:0][1:0] sel;
    logic [1:0][3:0] word, mux_i;
    int              n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign y[g] = mux_i[g][sel[g]];
        mux_scan_ctrl #(.NUM_CH(N), .SEL_W(2), .SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .y_in(y[g]), .sel(sel[g]),
            .busy(busy[g]), .word_out(word[g]), .word_valid(valid[g]), .word_ready(ready[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel c is sampled on the edge (c+1)*(s+1) after the start edge, so bit c is
    // whatever the mux shows on channel c during the cycle just before that edge.
    task automatic scan(input int d, input int s, input logic [3:0] i0, input logic [3:0] i1,
                        input int chg, input bit poke, output logic [3:0] w);
        int per = s + 1;
        w = '0;
        mux_i[d] = i0;
        start[d] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= N * per; k++) begin
            start[d] = poke && (k == 2);
            if (k == chg) mux_i[d] = i1;
            check("busy_scan", busy[d], 1);
            check("sel_sched", sel[d], (k - 1) / per);
            check("valid_early", valid[d], 0);
            if (k % per == 0) w[(k - 1) / per] = mux_i[d][(k - 1) / per];
            @(negedge clk);
        end
        start[d] = 1'b0;
        check("valid_rise", valid[d], 1);
        check("word", word[d], w);
    endtask

    task automatic hold(input int d, input int n, input logic [3:0] w, input bit st);
        for (int k = 0; k < n; k++) begin
            start[d] = st;
            check("hold_valid", valid[d], 1);
            check("hold_word", word[d], w);
            check("hold_sel", sel[d], 3);
            @(negedge clk);
        end
        ready[d] = 1'b1;
        start[d] = st;
        @(negedge clk);
        ready[d] = 1'b0;
        start[d] = 1'b0;
        check("hs_valid", valid[d], 0);
`ifdef MUX_SCAN_CONTINUOUS_EN
        check("cont_busy", busy[d], 1);
        check("cont_sel", sel[d], 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        check("idle_busy", busy[d], 0);
        check("idle_word", word[d], w);
        @(negedge clk);
        check("idle_stay", busy[d], 0);
        check("idle_nov", valid[d], 0);
`endif
    endtask

    initial begin
        logic [3:0] w;
        int d;
        start = '0;
        ready = '0;
        mux_i = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_sel", sel[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_valid", valid[i], 0);
            check("rst_word", word[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        scan(0, 1, 4'b1101, 4'b1101, 0, 0, w);
        check("basic_word", w, 4'b1101);
        hold(0, 5, w, 0);
        scan(1, 3, 4'b1101, 4'b1001, 1, 0, w);
        check("settle3_word", w, 4'b1001);
        hold(1, 0, w, 0);
        scan(0, 1, 4'b0110, 4'b0110, 0, 1, w);
        hold(0, 3, w, 1);
        mux_i[0] = 4'b1011;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_sel", sel[0], 2);
        rst_n = 1'b0;
        #1;
        check("arst_sel", sel[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_valid", valid[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan(0, 1, 4'b1011, 4'b1011, 0, 0, w);
        check("post_rst_word", w, 4'b1011);
        hold(0, 1, w, 0);
        for (int r = 0; r < 20; r++) begin
            d = int'($urandom_range(0, 1));
            scan(d, d ? 3 : 1, 4'($urandom), 4'($urandom), int'($urandom_range(1, N * (d ? 4 : 2))),
                 1'($urandom_range(0, 1)), w);
            hold(d, int'($urandom_range(0, 3)), w, 1'($urandom_range(0, 1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
